// File: rtl/unidade_mult_div_if.sv
// Multiply/divide unit port bundle: start/opcode/operands in, busy/done/HI/LO out.
// master = execute-stage control, slave = the multi-cycle unit.
interface unidade_mult_div_if #(
    parameter int LARGURA = 32
);
    logic               inicio;
    logic [1:0]         operacao;
    logic [LARGURA-1:0] dados1;
    logic [LARGURA-1:0] dados2;
    logic               ocupado;
    logic               pronto;
    logic [LARGURA-1:0] hi;
    logic [LARGURA-1:0] lo;

    modport master (
        output inicio, operacao, dados1, dados2,
        input  ocupado, pronto, hi, lo
    );

    modport slave (
        input  inicio, operacao, dados1, dados2,
        output ocupado, pronto, hi, lo
    );
endinterface

// File: rtl/unidade_mult_div.sv
// MIPS mult/multu/div/divu into HI/LO; result and one-cycle pronto LARGURA+1 edges after acceptance.
// ocupado holds the pipeline until then; inicio is ignored unless idle.
module unidade_mult_div #(
    parameter int LARGURA = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    unidade_mult_div_if.slave   mdu
);
    localparam int LC = $clog2(LARGURA);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        AJUSTA  = 2'd2
    } estado_t;

    estado_t                r_estado;
    estado_t                w_prox_estado;
    logic                   w_aceita;
    logic                   w_ocupado;

    logic                   r_eh_div;
    logic                   r_sinal1;
    logic                   r_sinal2;
    logic                   r_div_zero;
    logic [LARGURA-1:0]     r_mag2;
    logic [2*LARGURA-1:0]   r_acc;
    logic [LC-1:0]          r_cont;
    logic [LARGURA-1:0]     r_hi;
    logic [LARGURA-1:0]     r_lo;
    logic                   r_pronto;

    logic                   w_sinal1;
    logic                   w_sinal2;
    logic [LARGURA-1:0]     w_mag1;
    logic [LARGURA-1:0]     w_mag2;

    logic [LARGURA:0]       w_soma;
    logic [2*LARGURA-1:0]   w_acc_mult;
    logic [LARGURA:0]       w_rem_desl;
    logic                   w_cabe;
    logic [LARGURA-1:0]     w_rem_novo;
    logic [2*LARGURA-1:0]   w_acc_div;

    logic                   w_neg_res;
    logic [2*LARGURA-1:0]   w_prod;
    logic [LARGURA-1:0]     w_quoc;
    logic [LARGURA-1:0]     w_rest;
    logic [LARGURA-1:0]     w_hi_final;
    logic [LARGURA-1:0]     w_lo_final;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        w_aceita      = 1'b0;
        w_ocupado     = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (mdu.inicio) begin
                    w_aceita      = 1'b1;
                    w_prox_estado = CALCULA;
                end
            end
            CALCULA: begin
                w_ocupado = 1'b1;
                if (r_cont == LC'(LARGURA - 1)) begin
                    w_prox_estado = AJUSTA;
                end
            end
            AJUSTA: begin
                w_ocupado     = 1'b1;
                w_prox_estado = OCIOSO;
            end
            default: begin
                w_prox_estado = OCIOSO;
            end
        endcase
    end

    // Signs are only meaningful for the signed opcodes (operacao[0]=0).
    assign w_sinal1 = ~mdu.operacao[0] & mdu.dados1[LARGURA-1];
    assign w_sinal2 = ~mdu.operacao[0] & mdu.dados2[LARGURA-1];
    assign w_mag1   = w_sinal1 ? -mdu.dados1 : mdu.dados1;
    assign w_mag2   = w_sinal2 ? -mdu.dados2 : mdu.dados2;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign w_soma     = {1'b0, r_acc[2*LARGURA-1:LARGURA]}
                      + {1'b0, (r_acc[0] ? r_mag2 : {LARGURA{1'b0}})};
    assign w_acc_mult = {w_soma, r_acc[LARGURA-1:1]};

    // Restoring division: {remainder, dividend/quotient} shifts left one bit per edge.
    assign w_rem_desl = r_acc[2*LARGURA-1:LARGURA-1];
    assign w_cabe     = (w_rem_desl >= {1'b0, r_mag2});
    assign w_rem_novo = w_cabe ? (w_rem_desl[LARGURA-1:0] - r_mag2) : w_rem_desl[LARGURA-1:0];
    assign w_acc_div  = {w_rem_novo, r_acc[LARGURA-2:0], w_cabe};

    assign w_neg_res = r_sinal1 ^ r_sinal2;
    assign w_prod    = w_neg_res ? -r_acc : r_acc;
    assign w_quoc    = r_div_zero ? {LARGURA{1'b1}}
                     : (w_neg_res ? -r_acc[LARGURA-1:0] : r_acc[LARGURA-1:0]);
    // With a zero divisor the remainder ends up as |dados1|, so restoring the
    // dividend sign gives back dados1 unmodified.
    assign w_rest    = r_sinal1 ? -r_acc[2*LARGURA-1:LARGURA] : r_acc[2*LARGURA-1:LARGURA];

    assign w_hi_final = r_eh_div ? w_rest : w_prod[2*LARGURA-1:LARGURA];
    assign w_lo_final = r_eh_div ? w_quoc : w_prod[LARGURA-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_eh_div   <= 1'b0;
            r_sinal1   <= 1'b0;
            r_sinal2   <= 1'b0;
            r_div_zero <= 1'b0;
            r_mag2     <= '0;
            r_acc      <= '0;
            r_cont     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_pronto   <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            if (w_aceita) begin
                r_eh_div   <= mdu.operacao[1];
                r_sinal1   <= w_sinal1;
                r_sinal2   <= w_sinal2;
                r_div_zero <= mdu.operacao[1] & (mdu.dados2 == '0);
                r_mag2     <= w_mag2;
                r_acc      <= {{LARGURA{1'b0}}, w_mag1};
                r_cont     <= '0;
            end else if (r_estado == CALCULA) begin
                r_acc  <= r_eh_div ? w_acc_div : w_acc_mult;
                r_cont <= r_cont + LC'(1);
            end else if (r_estado == AJUSTA) begin
                r_hi     <= w_hi_final;
                r_lo     <= w_lo_final;
                r_pronto <= 1'b1;
            end
        end
    end

    assign mdu.ocupado = w_ocupado;
    assign mdu.pronto  = r_pronto;
    assign mdu.hi      = r_hi;
    assign mdu.lo      = r_lo;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Self-checking bench for unidade_mult_div: vector table through a scoreboard plus abort/ignore sequences.
module tb_unidade_mult_div;
    localparam int L = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    unidade_mult_div_if #(.LARGURA(L)) mdu ();
    unidade_mult_div #(.LARGURA(L)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .mdu     (mdu)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [L-1:0] hi;
        logic [L-1:0] lo;
    } res_t;
    res_t sb[$];
    res_t mon_e;

    typedef struct {
        logic [1:0]   op;
        logic [L-1:0] a;
        logic [L-1:0] b;
        logic [L-1:0] ehi;
        logic [L-1:0] elo;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string nome, input logic [L-1:0] atual, input logic [L-1:0] esperado);
        checks++;
        if (atual !== esperado) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    // Scoreboard consumer: every pronto pulse must match the oldest pending op.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && mdu.pronto === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pronto_spurious: got pronto=1 expected no pending op");
            end else begin
                mon_e = sb.pop_front();
                chk("sb_hi", mdu.hi, mon_e.hi);
                chk("sb_lo", mdu.lo, mon_e.lo);
            end
        end
    end

    task automatic start(input logic [1:0] op, input logic [L-1:0] a, input logic [L-1:0] b,
                         input logic [L-1:0] ehi, input logic [L-1:0] elo);
        @(negedge clock);
        mdu.operacao = op;
        mdu.dados1   = a;
        mdu.dados2   = b;
        mdu.inicio   = 1'b1;
        sb.push_back({ehi, elo});
        @(negedge clock);
        mdu.inicio   = 1'b0;
        mdu.operacao = 2'($urandom);
        mdu.dados1   = $urandom;
        mdu.dados2   = $urandom;
    endtask

    task automatic wait_done(input bit timing);
        int cyc  = 0;
        int ocup = 0;
        while (mdu.pronto !== 1'b1 && cyc < 200) begin
            if (mdu.ocupado === 1'b1) ocup++;
            cyc++;
            @(negedge clock);
        end
        if (cyc >= 200) begin
            checks++;
            failures++;
            $display("FAIL timeout: got no pronto within %0d cycles expected pronto", cyc);
            sb.delete();
        end else begin
            chk("ocupado_at_pronto", {31'b0, mdu.ocupado}, 32'd0);
            if (timing) begin
                chk("latency", cyc, L + 1);
                chk("ocupado_cycles", ocup, L + 1);
            end
            @(negedge clock);
            chk("pronto_pulse", {31'b0, mdu.pronto}, 32'd0);
        end
    endtask

    initial begin
        int npr;
        mdu.inicio   = 1'b0;
        mdu.operacao = 2'b00;
        mdu.dados1   = '0;
        mdu.dados2   = '0;

        vecs[0]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[5]  = '{2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
        vecs[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
        vecs[9]  = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        vecs[10] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};

        repeat (3) @(negedge clock);
        chk("rst_ocupado", {31'b0, mdu.ocupado}, 32'd0);
        chk("rst_pronto", {31'b0, mdu.pronto}, 32'd0);
        chk("rst_hi", mdu.hi, 32'd0);
        chk("rst_lo", mdu.lo, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_ocupado", {31'b0, mdu.ocupado}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);
            wait_done(1'b1);
            repeat (3) @(negedge clock);
            chk("hold_hi", mdu.hi, vecs[i].ehi);
            chk("hold_lo", mdu.lo, vecs[i].elo);
        end

        // A start request during an operation must not disturb it.
        start(2'b00, 32'd5, 32'd6, 32'd0, 32'd30);
        repeat (9) @(negedge clock);
        mdu.operacao = 2'b11;
        mdu.dados1   = 32'd9;
        mdu.dados2   = 32'd3;
        mdu.inicio   = 1'b1;
        @(negedge clock);
        mdu.inicio   = 1'b0;
        wait_done(1'b0);
        chk("ignored_hi", mdu.hi, 32'd0);
        chk("ignored_lo", mdu.lo, 32'd30);
        repeat (5) @(negedge clock);
        chk("ignored_no_second_op", {31'b0, mdu.ocupado}, 32'd0);

        // Reset mid-operation discards the op and clears HI/LO.
        start(2'b00, 32'd5, 32'd6, 32'd0, 32'd30);
        repeat (14) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("abort_ocupado", {31'b0, mdu.ocupado}, 32'd0);
        chk("abort_pronto", {31'b0, mdu.pronto}, 32'd0);
        chk("abort_hi", mdu.hi, 32'd0);
        chk("abort_lo", mdu.lo, 32'd0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        npr = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (mdu.pronto === 1'b1) npr++;
        end
        chk("abort_no_pronto", npr, 32'd0);
        start(2'b11, 32'd9, 32'd3, 32'd0, 32'd3);
        wait_done(1'b1);
        chk("after_abort_hi", mdu.hi, 32'd0);
        chk("after_abort_lo", mdu.lo, 32'd3);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
